// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiplier slice.
//   state_t          : controller states
//   cnt_width()      : width of the step counter for a given number of steps
//   digit_bits_legal : reports whether a digit size is supported
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A counter for a single step still needs one bit.
    function automatic int cnt_width(input int steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

    function automatic bit digit_bits_legal(input int digit_bits);
        return (digit_bits == 1) || (digit_bits == 2) || (digit_bits == 4);
    endfunction

endpackage

// File: rtl/mul_digit_pp.sv
// Combinational WIDTH x DIGIT_BITS partial product. It is kept as its own
// module so that approximate partial-product generators can be dropped in.
//   a     [WIDTH-1:0]            : multiplicand magnitude
//   digit [DIGIT_BITS-1:0]       : current multiplier digit
//   pp    [WIDTH+DIGIT_BITS-1:0] : a * digit, exact
module mul_digit_pp #(
    parameter int WIDTH      = 16,
    parameter int DIGIT_BITS = 1
) (
    input  logic [WIDTH-1:0]            a,
    input  logic [DIGIT_BITS-1:0]       digit,
    output logic [WIDTH+DIGIT_BITS-1:0] pp
);

    localparam int PW = WIDTH + DIGIT_BITS;

    // Shift-and-add over the digit bits; for DIGIT_BITS=1 this is an AND row.
    always_comb begin
        pp = '0;
        for (int i = 0; i < DIGIT_BITS; i++) begin
            if (digit[i]) begin
                pp = pp + (PW'(a) << i);
            end
        end
    end

endmodule

// File: rtl/mul_seq.sv
// Iterative multi-cycle integer multiplier, DIGIT_BITS multiplier bits per
// clock, with per-operation signed/unsigned mode.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake
//   in_signed, in_a, in_b : operation mode and operands
//   abort                 : synchronous cancel of the current operation
//   out_valid / out_ready : product handshake
//   out_p [2*WIDTH-1:0]   : product, held until consumed
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p
);

    localparam int  STEPS    = WIDTH / DIGIT_BITS;
    localparam int  CNT_W    = cnt_width(STEPS);
    localparam bit  DIGIT_OK = digit_bits_legal(DIGIT_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    generate
        if (!DIGIT_OK || (WIDTH % DIGIT_BITS) != 0) begin : g_bad_cfg
            $error("mul_seq: DIGIT_BITS must be 1, 2 or 4 and divide WIDTH");
        end
    endgenerate

    state_t                     state;
    logic [WIDTH-1:0]           a_mag;
    logic [WIDTH-1:0]           b_mag;
    logic                       neg;
    logic [2*WIDTH-1:0]         acc;
    logic [CNT_W-1:0]           cnt;

    logic [WIDTH-1:0]            a_abs;
    logic [WIDTH-1:0]            b_abs;
    logic [WIDTH+DIGIT_BITS-1:0] pp;
    logic [WIDTH+DIGIT_BITS-1:0] sum_hi;
    logic [2*WIDTH+DIGIT_BITS-1:0] sum_cat;
    logic [2*WIDTH-1:0]          acc_next;

    // Magnitudes of the incoming operands; -2^(WIDTH-1) maps onto itself,
    // which is the correct unsigned magnitude.
    assign a_abs = (in_signed && in_a[WIDTH-1]) ? (~in_a + 1'b1) : in_a;
    assign b_abs = (in_signed && in_b[WIDTH-1]) ? (~in_b + 1'b1) : in_b;

    mul_digit_pp #(
        .WIDTH      (WIDTH),
        .DIGIT_BITS (DIGIT_BITS)
    ) u_pp (
        .a     (a_mag),
        .digit (b_mag[DIGIT_BITS-1:0]),
        .pp    (pp)
    );

    // Right-shifting accumulator: the digit product is added to the upper
    // half and the whole register moves down by one digit per step, so the
    // positional weighting needs no variable shifter. After STEPS steps the
    // accumulator holds the full product. The upper-half sum cannot overflow
    // WIDTH+DIGIT_BITS bits because the upper half stays below 2^WIDTH.
    assign sum_hi   = {{DIGIT_BITS{1'b0}}, acc[2*WIDTH-1:WIDTH]} + pp;
    assign sum_cat  = {sum_hi, acc[WIDTH-1:0]};
    assign acc_next = sum_cat[2*WIDTH+DIGIT_BITS-1:DIGIT_BITS];

    // Controller and datapath registers. abort wins over everything except
    // reset, including completion on the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_p     <= '0;
            cnt       <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            neg       <= 1'b0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !abort) begin
                        a_mag    <= a_abs;
                        b_mag    <= b_abs;
                        neg      <= (in_a[WIDTH-1] ^ in_b[WIDTH-1]) & in_signed;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (abort) begin
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        acc   <= acc_next;
                        b_mag <= b_mag >> DIGIT_BITS;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            out_p     <= neg ? (~acc_next + 1'b1) : acc_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq. Two instances (DIGIT_BITS=1 and 4, both
// WIDTH=16) are exercised one after the other by the same scenario tasks.
// Expected products come from an integer reference model and travel through
// a scoreboard queue from the accepting edge to the output handshake.
module tb_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [2];
    logic        in_signed [2];
    logic [15:0] in_a      [2];
    logic [15:0] in_b      [2];
    logic        abort     [2];
    logic        out_ready [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic [31:0] out_p     [2];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mul_seq #(
            .WIDTH      (16),
            .DIGIT_BITS ((g == 0) ? 1 : 4)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_signed (in_signed[g]),
            .in_a      (in_a[g]),
            .in_b      (in_b[g]),
            .abort     (abort[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_p     (out_p[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int steps_of(input int u);
        return (u == 0) ? 16 : 4;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({48'd0, a});
            sb = longint'({48'd0, b});
        end
        p = 64'(sa * sb);
        return p[31:0];
    endfunction

    function automatic logic [15:0] pick_operand();
        logic [15:0] corners [5];
        corners[0] = 16'h0000;
        corners[1] = 16'h0001;
        corners[2] = 16'h7FFF;
        corners[3] = 16'h8000;
        corners[4] = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    // Called and returns at posedge+1. Waits for in_ready, presents one
    // operation for one edge and records its expected product.
    task automatic send_op(input int u, input logic [15:0] a, input logic [15:0] b,
                           input logic s);
        int n = 0;
        while (in_ready[u] !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready[u] !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout u=%0d: in_ready=%b, required 1", u, in_ready[u]);
        end
        in_a[u]      = a;
        in_b[u]      = b;
        in_signed[u] = s;
        in_valid[u]  = 1'b1;
        @(posedge clk); #1;
        in_valid[u]  = 1'b0;
        in_a[u]      = 16'($urandom);
        in_b[u]      = 16'($urandom);
        in_signed[u] = 1'($urandom);
        exp_q.push_back(ref_mul(a, b, s));
    endtask

    // Counts edges after the accepting edge until out_valid is seen.
    task automatic wait_valid(input int u, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (out_valid[u] !== 1'b1 && n < 200);
    endtask

    task automatic test_reset(input int u);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0 || out_p[u] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_values u=%0d: in_ready=%b out_valid=%b out_p=%h, required 1 0 00000000",
                     u, in_ready[u], out_valid[u], out_p[u]);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned(input int u);
        logic [15:0] as [2];
        logic [15:0] bs [2];
        logic [31:0] exp;
        int          n;
        as[0] = 16'hFFFF; bs[0] = 16'hFFFF;
        as[1] = 16'h0000; bs[1] = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            send_op(u, as[i], bs[i], 1'b0);
            wait_valid(u, n);
            checks++;
            if (n != steps_of(u)) begin
                errors++;
                $display("[TB] FAIL unsigned_latency u=%0d: %0d edges, required %0d", u, n, steps_of(u));
            end
            exp = exp_q.pop_front();
            checks++;
            if (out_p[u] !== exp) begin
                errors++;
                $display("[TB] FAIL unsigned_product u=%0d %h*%h: out_p=%h, required %h",
                         u, as[i], bs[i], out_p[u], exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_signed(input int u);
        logic [15:0] as [3];
        logic [15:0] bs [3];
        logic [31:0] fixed [3];
        logic [31:0] exp;
        int          n;
        as[0] = 16'h8000; bs[0] = 16'h8000; fixed[0] = 32'h40000000;
        as[1] = 16'hFFFF; bs[1] = 16'h0001; fixed[1] = 32'hFFFFFFFF;
        as[2] = 16'h7FFF; bs[2] = 16'h8000; fixed[2] = 32'hC0008000;
        for (int i = 0; i < 3; i++) begin
            send_op(u, as[i], bs[i], 1'b1);
            wait_valid(u, n);
            exp = exp_q.pop_front();
            checks++;
            if (out_valid[u] !== 1'b1 || out_p[u] !== exp || out_p[u] !== fixed[i]) begin
                errors++;
                $display("[TB] FAIL signed_product u=%0d %h*%h: out_valid=%b out_p=%h, required 1 %h",
                         u, as[i], bs[i], out_valid[u], out_p[u], fixed[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure(input int u);
        logic [31:0] exp;
        int          n;
        out_ready[u] = 1'b0;
        send_op(u, 16'hABCD, 16'h1357, 1'b1);
        wait_valid(u, n);
        exp = exp_q.pop_front();
        checks++;
        if (out_valid[u] !== 1'b1 || out_p[u] !== exp) begin
            errors++;
            $display("[TB] FAIL stall_first u=%0d: out_valid=%b out_p=%h, required 1 %h",
                     u, out_valid[u], out_p[u], exp);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid[u] !== 1'b1 || in_ready[u] !== 1'b0 || out_p[u] !== exp) begin
                errors++;
                $display("[TB] FAIL stall_hold u=%0d cycle %0d: out_valid=%b in_ready=%b out_p=%h, required 1 0 %h",
                         u, c, out_valid[u], in_ready[u], out_p[u], exp);
            end
        end
        out_ready[u] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release u=%0d: out_valid=%b in_ready=%b, required 0 1",
                     u, out_valid[u], in_ready[u]);
        end
    endtask

    task automatic test_abort(input int u);
        logic [31:0] exp;
        logic        seen;
        int          n;
        send_op(u, 16'h1234, 16'h5678, 1'b0);
        void'(exp_q.pop_back());
        repeat (3) begin
            @(posedge clk); #1;
        end
        abort[u] = 1'b1;
        @(posedge clk); #1;
        abort[u] = 1'b0;
        checks++;
        if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_calc u=%0d: out_valid=%b in_ready=%b, required 0 1",
                     u, out_valid[u], in_ready[u]);
        end
        seen = 1'b0;
        for (int c = 0; c < steps_of(u) + 4; c++) begin
            @(posedge clk); #1;
            if (out_valid[u] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_output u=%0d: out_valid pulse seen=%b, required 0", u, seen);
        end
        // abort in IDLE must block an offered operation
        abort[u]    = 1'b1;
        in_valid[u] = 1'b1;
        in_a[u]     = 16'h0009;
        in_b[u]     = 16'h0009;
        @(posedge clk); #1;
        abort[u]    = 1'b0;
        in_valid[u] = 1'b0;
        checks++;
        if (in_ready[u] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_idle u=%0d: in_ready=%b, required 1", u, in_ready[u]);
        end
        send_op(u, 16'h0003, 16'h0005, 1'b0);
        wait_valid(u, n);
        exp = exp_q.pop_front();
        checks++;
        if (out_p[u] !== exp || out_p[u] !== 32'h0000000F) begin
            errors++;
            $display("[TB] FAIL abort_next_op u=%0d: out_p=%h, required 0000000f", u, out_p[u]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid(input int u);
        logic [31:0] exp;
        int          n;
        send_op(u, 16'h4321, 16'h1234, 1'b0);
        void'(exp_q.pop_back());
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0 || out_p[u] !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid u=%0d: in_ready=%b out_valid=%b out_p=%h, required 1 0 00000000",
                     u, in_ready[u], out_valid[u], out_p[u]);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_op(u, 16'h00FF, 16'h0100, 1'b0);
        wait_valid(u, n);
        exp = exp_q.pop_front();
        checks++;
        if (n != steps_of(u) || out_p[u] !== exp || out_p[u] !== 32'h0000FF00) begin
            errors++;
            $display("[TB] FAIL reset_next_op u=%0d: latency=%0d out_p=%h, required %0d 0000ff00",
                     u, n, out_p[u], steps_of(u));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back(input int u);
        logic [31:0] exp;
        int          n;
        for (int i = 0; i < 3; i++) begin
            send_op(u, 16'(16'h1111 * (i + 1)), 16'(16'hF00F - i), 1'(i & 1));
            wait_valid(u, n);
            exp = exp_q.pop_front();
            checks++;
            if (out_p[u] !== exp) begin
                errors++;
                $display("[TB] FAIL back_to_back u=%0d op %0d: out_p=%h, required %h", u, i, out_p[u], exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random(input int u, input int count);
        logic [31:0] exp;
        logic        done;
        for (int i = 0; i < count; i++) begin
            send_op(u, pick_operand(), pick_operand(), 1'($urandom));
            done = 1'b0;
            for (int c = 0; c < 200 && !done; c++) begin
                out_ready[u] = ($urandom_range(0, 2) != 0);
                if (out_valid[u] === 1'b1 && out_ready[u] === 1'b1) begin
                    exp = exp_q.pop_front();
                    checks++;
                    if (out_p[u] !== exp) begin
                        errors++;
                        $display("[TB] FAIL random u=%0d op %0d: out_p=%h, required %h", u, i, out_p[u], exp);
                    end
                    done = 1'b1;
                end
                @(posedge clk); #1;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("[TB] FAIL random_timeout u=%0d op %0d: no product, required one", u, i);
                void'(exp_q.pop_front());
            end
        end
        out_ready[u] = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            in_valid[u]  = 1'b0;
            in_signed[u] = 1'b0;
            in_a[u]      = 16'h0;
            in_b[u]      = 16'h0;
            abort[u]     = 1'b0;
            out_ready[u] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int u = 0; u < 2; u++) begin
            $display("[TB] unit %0d, DIGIT_BITS=%0d", u, (u == 0) ? 1 : 4);
            exp_q.delete();
            test_reset(u);
            test_unsigned(u);
            test_signed(u);
            test_backpressure(u);
            test_abort(u);
            test_reset_mid(u);
            test_back_to_back(u);
            test_random(u, 60);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
